// File: rtl/memory_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding and
// default geometry.
package memory_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/memory_bank.sv
// Word storage: one synchronous write port, one combinational read port,
// synchronous clear on R (clear wins over a coincident write).
module memory_bank
    import memory_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              C,
    input  logic              R,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge C) begin
        if (R) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single memory_bank; one access per 3 cycles.
// Define MEMORY_ARB_ROUND_ROBIN_EN for round-robin instead of port-0 priority.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              C,
    input  logic              R,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [WIDTH-1:0]  rdata,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              win;
    logic              owner;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [WIDTH-1:0]  l_wdata;
    logic [WIDTH-1:0]  bank_rdata;

    assign grant = (state == IDLE) && (req0 || req1);

`ifdef MEMORY_ARB_ROUND_ROBIN_EN
    logic last;

    // On a tie, the port that was not served last wins
    assign win = (req0 && req1) ? ~last : ~req0;

    always_ff @(posedge C) begin
        if (R) begin
            last <= 1'b1;
        end else if (grant) begin
            last <= win;
        end
    end
`else
    assign win = ~req0;
`endif

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        ack0      = 1'b0;
        ack1      = 1'b0;
        unique case (state)
            IDLE: if (req0 || req1) state_nxt = ACC;
            ACC:  state_nxt = RESP;
            RESP: begin
                state_nxt = IDLE;
                ack0      = ~owner;
                ack1      = owner;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state   <= IDLE;
            owner   <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner   <= win;
                l_we    <= win ? we1 : we0;
                l_addr  <= win ? addr1 : addr0;
                l_wdata <= win ? wdata1 : wdata0;
            end
            if (state == ACC && !l_we) begin
                rdata <= bank_rdata;
            end
        end
    end

    memory_bank #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .C     (C),
        .R     (R),
        .we    (state == ACC && l_we),
        .waddr (l_addr),
        .wdata (l_wdata),
        .raddr (l_addr),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random
// traffic, checked cycle by cycle against a transaction-level model.
module tb_memory_arbiter;

    localparam int W = 8;
    localparam int A = 2;

    logic         C = 1'b0;
    logic         R;
    logic         req0, req1, we0, we1;
    logic [A-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         ack0, ack1, busy;
    logic [W-1:0] rdata;

    memory_arbiter #(.WIDTH(W), .ADDR_W(A)) dut (
        .C      (C),
        .R      (R),
        .req0   (req0),
        .req1   (req1),
        .we0    (we0),
        .we1    (we1),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rdata  (rdata),
        .busy   (busy)
    );

    always #5 C = ~C;

    int n_tests = 0;
    int n_fail  = 0;

    // Port drivers: a request stays up until its ack (or forever when held)
    bit           act[2];
    bit           hold[2];
    bit           dwe[2];
    logic [A-1:0] dad[2];
    logic [W-1:0] dwd[2];
    bit           acked[2];
    int           d_ack[2];

    // Transaction-level model: a grant at cycle g is acked at g+2,
    // the arbiter is free again at g+3
    logic [W-1:0] m_mem[4];
    logic [W-1:0] m_rd;
    int           m_last;
    int           cyc;
    int           g_at;
    int           g_port;
    bit           g_we;
    logic [A-1:0] g_addr;
    logic [W-1:0] g_data;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic apply();
        req0   = act[0];
        req1   = act[1];
        we0    = dwe[0];
        we1    = dwe[1];
        addr0  = dad[0];
        addr1  = dad[1];
        wdata0 = dwd[0];
        wdata1 = dwd[1];
    endtask

    task automatic tick();
        bit resp, eb, ea0, ea1;
        resp = (cyc == g_at + 2);
        eb   = (cyc == g_at + 1) || resp;
        ea0  = resp && g_port == 0;
        ea1  = resp && g_port == 1;
        apply();
        @(negedge C);
        check("busy", 32'(busy), 32'(eb));
        check("ack0", 32'(ack0), 32'(ea0));
        check("ack1", 32'(ack1), 32'(ea1));
        if (ack0 === 1'b1) d_ack[0]++;
        if (ack1 === 1'b1) d_ack[1]++;
        acked[0] = ea0;
        acked[1] = ea1;
        if (resp) begin
            if (g_we) begin
                check("rdata_hold", 32'(rdata), 32'(m_rd));
                m_mem[g_addr] = g_data;
            end else begin
                m_rd = m_mem[g_addr];
                check("rdata", 32'(rdata), 32'(m_rd));
            end
        end
        if (R) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_rd   = '0;
            m_last = 1;
            g_at   = -100;
        end else if (cyc >= g_at + 3 && (act[0] || act[1])) begin
            if (act[0] && act[1]) begin
`ifdef MEMORY_ARB_ROUND_ROBIN_EN
                g_port = (m_last == 0) ? 1 : 0;
`else
                g_port = 0;
`endif
            end else begin
                g_port = act[0] ? 0 : 1;
            end
            m_last = g_port;
            g_at   = cyc;
            g_we   = dwe[g_port];
            g_addr = dad[g_port];
            g_data = dwd[g_port];
        end
        @(posedge C);
        #1;
        cyc++;
    endtask

    task automatic op(int p, bit w, int a, int d);
        act[p] = 1'b1;
        dwe[p] = w;
        dad[p] = A'(a);
        dwd[p] = W'(d);
    endtask

    task automatic run(int n, bit rnd);
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (rnd && !act[p] && $urandom_range(0, 2) == 0) begin
                    op(p, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
                end else if (act[p] && !hold[p] && g_port == p &&
                             cyc > g_at && cyc <= g_at + 2) begin
                    // granted port's inputs are scrambled while the access runs
                    dwe[p] = 1'($urandom_range(0, 1));
                    dad[p] = A'($urandom_range(0, 3));
                    dwd[p] = W'($urandom_range(0, 255));
                end
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                if (acked[p] && !hold[p]) act[p] = 1'b0;
            end
        end
    endtask

    initial begin
        cyc    = 0;
        g_at   = -100;
        g_port = 0;
        m_last = 1;
        m_rd   = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; hold[p] = 0; dwe[p] = 0; dad[p] = '0; dwd[p] = '0;
        end
        R = 1'b1;
        apply();
        @(posedge C);
        #1;
        tick();
        check("rst_rdata", 32'(rdata), 32'h0);
        R = 1'b0;

        // read right after reset
        op(1, 0, 3, 0);
        run(4, 0);
        // write A5 to addr 2, then read it back from port 1
        op(0, 1, 2, 8'hA5);
        run(4, 0);
        op(1, 0, 2, 0);
        run(4, 0);

        // simultaneous reads, single port-0 read, simultaneous reads again
        op(0, 0, 2, 0);
        op(1, 0, 1, 0);
        run(7, 0);
        op(0, 0, 0, 0);
        run(4, 0);
        op(0, 0, 2, 0);
        op(1, 0, 2, 0);
        run(7, 0);

        // reset lands in the ACC cycle of a write: no ack, no commit
        op(0, 1, 1, 8'h3C);
        tick();
        R = 1'b1;
        tick();
        R = 1'b0;
        act[0] = 1'b0;
        run(2, 0);
        op(0, 0, 1, 0);
        run(4, 0);

        // port 0 holds its request: ack0 every 3rd cycle, never ack1
        d_ack[0] = 0;
        d_ack[1] = 0;
        hold[0]  = 1'b1;
        op(0, 0, 0, 0);
        run(12, 0);
        check("hold_ack0", 32'(d_ack[0]), 32'd4);
        check("hold_ack1", 32'(d_ack[1]), 32'd0);
        hold[0] = 1'b0;
        act[0]  = 1'b0;
        run(2, 0);

        // random traffic, then drain and confirm nothing was dropped
        run(600, 1);
        run(20, 0);
        check("drain0", 32'(act[0]), 32'd0);
        check("drain1", 32'(act[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
